systolic_sched: RTL

Job sequencer for the 4x4 systolic multiply datapath: transposer pair, systolic array and 4-lane output adder. A single calc_init starts a job of n_tiles output tiles, each accumulating n_k K-slices. For every slice it runs LOAD, then CALC, and it ends each tile with a WRITE burst. It drives BRAM read/write addresses and enables, transposer ping-pong select, and systolic mode/state. It replaces hand-sequencing inside the memory controller.

---
 rtl/mul_pkg.sv | 32 +++
 rtl/sched_beat_cnt.sv | 32 +++
 rtl/systolic_sched.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Purpose : shared types and constants for the 4x4 systolic multiply datapath.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: array/data width constants, memory-mode and scheduler-state enums,
//           and the memory-mode to systolic-mode mapping.
package mul_pkg;

  localparam int SYSTOLIC_WIDTH = 4;
  localparam int DATA_WIDTH     = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AS   = 3'd1,
    SA   = 3'd2,
    SB   = 3'd3,
    BS   = 3'd4
  } mem_mode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CALC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } sched_state_e;

  // AS/SA run output-stationary, SB/BS weight-stationary.
  function automatic logic mode_to_systolic(input logic [2:0] mode);
    return (mode == AS) || (mode == SA);
  endfunction

endpackage

// File: rtl/sched_beat_cnt.sv
// Purpose : loadable up-counter with enable and terminal-count flag; wraps to 0 when
//           enabled at terminal count.
// Latency : count updates one cycle after en/ld; tc is combinational from the count.
// Backpressure: caller gates en (e.g. with hold) to freeze the count.
// Ports   : clk, rst_n, ld/ld_val (load, wins over en), en, last (terminal value),
//           cnt (current value), tc (cnt == last).
module sched_beat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/systolic_sched.sv
// Purpose : job sequencer for the systolic multiply datapath (LOAD/CALC per K-slice,
//           WRITE per tile), driving BRAM addresses/strobes and systolic controls.
// Latency : first rd_en one cycle after calc_init; done at 1 + n_tiles*(n_k*(W+CALC)+W).
// Backpressure: hold freezes state/counters/addresses and masks rd_en/wr_en that cycle.
// Ports   : clk, rst_n, calc_init, mem_mode, n_k, n_tiles, left/right/wr_base, hold in;
//           rd_en, rd_addr_left/right, wr_en, wr_addr, transposition_slect,
//           systolic_mode, systolic_state, busy, done, err, perf_cycles, perf_hold out.
// Option  : define SYSTOLIC_SCHED_PERF_EN to enable the busy/held cycle counters.
module systolic_sched #(
  parameter int SYSTOLIC_WIDTH = mul_pkg::SYSTOLIC_WIDTH,
  parameter int ADDR_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int CALC_CYCLES    = 2 * SYSTOLIC_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  calc_init,
  input  logic [2:0]            mem_mode,
  input  logic [CNT_WIDTH-1:0]  n_k,
  input  logic [CNT_WIDTH-1:0]  n_tiles,
  input  logic [ADDR_WIDTH-1:0] left_base,
  input  logic [ADDR_WIDTH-1:0] right_base,
  input  logic [ADDR_WIDTH-1:0] wr_base,
  input  logic                  hold,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr_left,
  output logic [ADDR_WIDTH-1:0] rd_addr_right,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  transposition_slect,
  output logic                  systolic_mode,
  output logic                  systolic_state,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_hold
);
  import mul_pkg::*;

  sched_state_e state, state_nxt;

  logic [CNT_WIDTH-1:0]  beat_cnt, calc_cnt, k_cnt, tile_cnt;
  logic                  beat_tc, calc_tc, k_tc, tile_tc;
  logic [CNT_WIDTH-1:0]  n_k_q, n_tiles_q;
  logic [ADDR_WIDTH-1:0] left_base_q, right_base_q, wr_base_q, left_off;
  logic                  mode_q, tsel_q, err_q;

  logic cfg_ok, start, beat_en, calc_en, k_en, tile_en, load_last;

  assign cfg_ok = (mem_mode != IDLE) && (mem_mode <= BS) && (n_k != '0) && (n_tiles != '0);
  assign start  = (state == S_IDLE) && calc_init && cfg_ok;

  // Counters wrap to 0 at terminal count, so k/tile are already clear when the
  // next tile/job would need them.
  assign beat_en   = !hold && ((state == S_LOAD) || (state == S_WRITE));
  assign calc_en   = !hold && (state == S_CALC);
  assign k_en      = calc_en && calc_tc;
  assign tile_en   = !hold && (state == S_WRITE) && beat_tc;
  assign load_last = !hold && (state == S_LOAD) && beat_tc;

  sched_beat_cnt #(.WIDTH(CNT_WIDTH)) u_beat (
    .clk(clk), .rst_n(rst_n), .ld(start), .ld_val('0), .en(beat_en),
    .last(CNT_WIDTH'(SYSTOLIC_WIDTH - 1)), .cnt(beat_cnt), .tc(beat_tc));

  sched_beat_cnt #(.WIDTH(CNT_WIDTH)) u_calc (
    .clk(clk), .rst_n(rst_n), .ld(start), .ld_val('0), .en(calc_en),
    .last(CNT_WIDTH'(CALC_CYCLES - 1)), .cnt(calc_cnt), .tc(calc_tc));

  sched_beat_cnt #(.WIDTH(CNT_WIDTH)) u_k (
    .clk(clk), .rst_n(rst_n), .ld(start), .ld_val('0), .en(k_en),
    .last(n_k_q - CNT_WIDTH'(1)), .cnt(k_cnt), .tc(k_tc));

  sched_beat_cnt #(.WIDTH(CNT_WIDTH)) u_tile (
    .clk(clk), .rst_n(rst_n), .ld(start), .ld_val('0), .en(tile_en),
    .last(n_tiles_q - CNT_WIDTH'(1)), .cnt(tile_cnt), .tc(tile_tc));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (load_last) state_nxt = S_CALC;
      S_CALC:  if (calc_en && calc_tc) state_nxt = k_tc ? S_WRITE : S_LOAD;
      S_WRITE: if (tile_en) state_nxt = tile_tc ? S_DONE : S_LOAD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job configuration, linear left-operand offset, ping-pong select, reject pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_k_q        <= '0;
      n_tiles_q    <= '0;
      left_base_q  <= '0;
      right_base_q <= '0;
      wr_base_q    <= '0;
      left_off     <= '0;
      mode_q       <= 1'b0;
      tsel_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= (state == S_IDLE) && calc_init && !cfg_ok;
      if (start) begin
        n_k_q        <= n_k;
        n_tiles_q    <= n_tiles;
        left_base_q  <= left_base;
        right_base_q <= right_base;
        wr_base_q    <= wr_base;
        left_off     <= '0;
        mode_q       <= mode_to_systolic(mem_mode);
        tsel_q       <= 1'b0;
      end else begin
        if (!hold && (state == S_LOAD)) left_off <= left_off + ADDR_WIDTH'(1);
        if (load_last) tsel_q <= ~tsel_q;
      end
    end
  end

  // Output logic
  always_comb begin
    rd_en               = (state == S_LOAD) && !hold;
    wr_en               = (state == S_WRITE) && !hold;
    systolic_state      = (state == S_CALC);
    busy                = (state == S_LOAD) || (state == S_CALC) || (state == S_WRITE);
    done                = (state == S_DONE);
    systolic_mode       = (state != S_IDLE) && mode_q;
    transposition_slect = tsel_q;
    err                 = err_q;
  end

  // Right operand restarts per tile because k_cnt is back at 0 for every tile.
  assign rd_addr_left  = left_base_q + left_off;
  assign rd_addr_right = right_base_q + ADDR_WIDTH'(k_cnt) * ADDR_WIDTH'(SYSTOLIC_WIDTH)
                         + ADDR_WIDTH'(beat_cnt);
  assign wr_addr       = wr_base_q + ADDR_WIDTH'(tile_cnt) * ADDR_WIDTH'(SYSTOLIC_WIDTH)
                         + ADDR_WIDTH'(beat_cnt);

`ifdef SYSTOLIC_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_hold   <= '0;
    end else if (start) begin
      perf_cycles <= '0;
      perf_hold   <= '0;
    end else if (busy) begin
      if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (hold && (perf_hold != '1)) perf_hold <= perf_hold + 32'd1;
    end
  end
`else
  assign perf_cycles = '0;
  assign perf_hold   = '0;
`endif

endmodule
